// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame parser.
package uart_cmd_pkg;

   localparam logic [7:0]  HDR_BYTE  = 8'hA5;
   localparam logic [7:0]  CMD_WR    = 8'h01;
   localparam logic [7:0]  CMD_RD    = 8'h02;
   localparam int unsigned FRAME_LEN = 5;
   localparam int unsigned STATE_W   = $clog2(FRAME_LEN);

   // One state per frame byte position: HDR, CMD, ADDR, DATA, CSUM.
   typedef enum logic [STATE_W-1:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_CSUM
   } state_t;

endpackage

// File: rtl/uart_cmd_parser.sv
// Decodes 5-byte HDR/CMD/ADDR/DATA/CSUM frames into register write/read strobes.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int unsigned ERR_CNT_W   = 8
`ifdef UART_CMD_TIMEOUT_EN
   ,
   parameter logic [15:0] TIMEOUT_CYC = 16'd1000
`endif
) (
   input  logic                 uart_clk_rx,
   input  logic                 RST_n,
   input  logic [7:0]           rx_byte,
   input  logic                 rx_valid,
   output logic                 reg_wr,
   output logic                 reg_rd,
   output logic [7:0]           reg_addr,
   output logic [7:0]           reg_wdata,
   output logic                 frame_ok,
   output logic                 frame_err,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic                 busy
);

   state_t r_state;
   state_t w_state_nxt;

   logic       r_is_wr, w_is_wr_nxt;
   logic [7:0] r_addr,  w_addr_nxt;
   logic [7:0] r_data,  w_data_nxt;
   logic [7:0] r_csum,  w_csum_nxt;

   logic                 w_wr_nxt, w_rd_nxt, w_ok_nxt, w_err_nxt;
   logic [7:0]           w_reg_addr_nxt, w_reg_wdata_nxt;
   logic [ERR_CNT_W-1:0] w_err_cnt_nxt;
   logic                 w_timeout;

`ifdef UART_CMD_TIMEOUT_EN
   logic [15:0] r_idle_cnt;

   assign w_timeout = (r_state != S_IDLE) && !rx_valid &&
                      (r_idle_cnt == TIMEOUT_CYC - 16'd1);

   // Idle counter: runs only mid-frame, cleared by any received byte.
   always_ff @(posedge uart_clk_rx) begin
      if (!RST_n || rx_valid || (w_state_nxt == S_IDLE)) begin
         r_idle_cnt <= 16'd0;
      end else begin
         r_idle_cnt <= r_idle_cnt + 16'd1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge uart_clk_rx) begin
      if (!RST_n) begin
         r_state   <= S_IDLE;
         r_is_wr   <= 1'b0;
         r_addr    <= 8'd0;
         r_data    <= 8'd0;
         r_csum    <= 8'd0;
         reg_wr    <= 1'b0;
         reg_rd    <= 1'b0;
         reg_addr  <= 8'd0;
         reg_wdata <= 8'd0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_cnt   <= '0;
         busy      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_is_wr   <= w_is_wr_nxt;
         r_addr    <= w_addr_nxt;
         r_data    <= w_data_nxt;
         r_csum    <= w_csum_nxt;
         reg_wr    <= w_wr_nxt;
         reg_rd    <= w_rd_nxt;
         reg_addr  <= w_reg_addr_nxt;
         reg_wdata <= w_reg_wdata_nxt;
         frame_ok  <= w_ok_nxt;
         frame_err <= w_err_nxt;
         err_cnt   <= w_err_cnt_nxt;
         busy      <= (w_state_nxt != S_IDLE);
      end
   end

   // Next-state, payload capture and strobe generation.
   always_comb begin
      w_state_nxt     = r_state;
      w_is_wr_nxt     = r_is_wr;
      w_addr_nxt      = r_addr;
      w_data_nxt      = r_data;
      w_csum_nxt      = r_csum;
      w_wr_nxt        = 1'b0;
      w_rd_nxt        = 1'b0;
      w_ok_nxt        = 1'b0;
      w_err_nxt       = 1'b0;
      w_reg_addr_nxt  = reg_addr;
      w_reg_wdata_nxt = reg_wdata;

      if (rx_valid) begin
         case (r_state)
            S_IDLE: begin
               if (rx_byte == HDR_BYTE) w_state_nxt = S_CMD;
            end
            S_CMD: begin
               if ((rx_byte == CMD_WR) || (rx_byte == CMD_RD)) begin
                  w_is_wr_nxt = (rx_byte == CMD_WR);
                  w_csum_nxt  = rx_byte;
                  w_state_nxt = S_ADDR;
               end else begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            S_ADDR: begin
               w_addr_nxt  = rx_byte;
               w_csum_nxt  = r_csum ^ rx_byte;
               w_state_nxt = S_DATA;
            end
            S_DATA: begin
               w_data_nxt  = rx_byte;
               w_csum_nxt  = r_csum ^ rx_byte;
               w_state_nxt = S_CSUM;
            end
            S_CSUM: begin
               if (rx_byte == r_csum) begin
                  w_ok_nxt       = 1'b1;
                  w_reg_addr_nxt = r_addr;
                  if (r_is_wr) begin
                     w_wr_nxt        = 1'b1;
                     w_reg_wdata_nxt = r_data;
                  end else begin
                     w_rd_nxt = 1'b1;
                  end
               end else begin
                  w_err_nxt = 1'b1;
               end
               w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end else if (w_timeout) begin
         w_err_nxt   = 1'b1;
         w_state_nxt = S_IDLE;
      end

      // Saturating error count: holds at all-ones.
      w_err_cnt_nxt = err_cnt;
      if (w_err_nxt && (err_cnt != {ERR_CNT_W{1'b1}})) begin
         w_err_cnt_nxt = err_cnt + ERR_CNT_W'(1);
      end
   end

endmodule
